// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch and data) for a single-ported, fixed-latency unified memory.
// One access in flight at a time; ties are granted round-robin; read data is held in registers.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DW      = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [DW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_valid,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [DW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_dm_valid,
  output logic [DW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  output logic          o_mem_re,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_stall_if,
  output logic          o_stall_mem
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIfWait = 2'd1,
    StDmWait = 2'd2
  } state_e;

  localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

  state_e        r_state;
  logic [2:0]    r_cnt;
  logic          r_last_dm;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic          r_if_valid;
  logic          r_dm_valid;

  logic w_if_eff;
  logic w_dm_eff;
  logic w_idle;
  logic w_grant_if;
  logic w_grant_dm;

  // A requester is ignored in its completion cycle so the old request is not re-issued.
  assign w_if_eff   = i_if_req & ~r_if_valid;
  assign w_dm_eff   = i_dm_req & ~r_dm_valid;
  assign w_idle     = (r_state == StIdle) & ~i_reset;
  assign w_grant_dm = w_idle & w_dm_eff & (~w_if_eff | ~r_last_dm);
  assign w_grant_if = w_idle & w_if_eff & (~w_dm_eff |  r_last_dm);

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    if (w_grant_if) begin
      o_mem_addr = i_if_addr;
      o_mem_re   = 1'b1;
    end else if (w_grant_dm) begin
      o_mem_addr  = i_dm_addr;
      o_mem_wdata = i_dm_wdata;
      o_mem_we    = i_dm_we;
      o_mem_re    = ~i_dm_we;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_cnt      <= 3'd0;
      r_last_dm  <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_if) begin
            r_state   <= StIfWait;
            r_cnt     <= 3'd1;
            r_last_dm <= 1'b0;
          end else if (w_grant_dm) begin
            r_last_dm <= 1'b1;
            // Stores complete in the following cycle without waiting for the memory.
            if (i_dm_we) begin
              r_dm_valid <= 1'b1;
            end else begin
              r_state <= StDmWait;
              r_cnt   <= 3'd1;
            end
          end
        end
        StIfWait: begin
          if (r_cnt == LAT_CNT) begin
            r_if_rdata <= i_mem_rdata;
            r_if_valid <= 1'b1;
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StDmWait: begin
          if (r_cnt == LAT_CNT) begin
            r_dm_rdata <= i_mem_rdata;
            r_dm_valid <= 1'b1;
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_if_valid  = r_if_valid;
  assign o_dm_valid  = r_dm_valid;
  assign o_stall_if  = i_if_req & ~r_if_valid;
  assign o_stall_mem = i_dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: transaction-level reference model predicts port activity and completions;
// a separate monitor pops the expected completions whenever the arbiter pulses a valid.
module tb_mem_port_arbiter;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned DW      = 32;

  logic          clk;
  logic          i_reset;
  logic          i_if_req;
  logic [DW-1:0] i_if_addr;
  logic [DW-1:0] o_if_rdata;
  logic          o_if_valid;
  logic          i_dm_req;
  logic          i_dm_we;
  logic [DW-1:0] i_dm_addr;
  logic [DW-1:0] i_dm_wdata;
  logic [DW-1:0] o_dm_rdata;
  logic          o_dm_valid;
  logic [DW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we;
  logic          o_mem_re;
  logic [DW-1:0] i_mem_rdata;
  logic          o_stall_if;
  logic          o_stall_mem;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .DW(DW)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_if_req   (i_if_req),
    .i_if_addr  (i_if_addr),
    .o_if_rdata (o_if_rdata),
    .o_if_valid (o_if_valid),
    .i_dm_req   (i_dm_req),
    .i_dm_we    (i_dm_we),
    .i_dm_addr  (i_dm_addr),
    .i_dm_wdata (i_dm_wdata),
    .o_dm_rdata (o_dm_rdata),
    .o_dm_valid (o_dm_valid),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_we   (o_mem_we),
    .o_mem_re   (o_mem_re),
    .i_mem_rdata(i_mem_rdata),
    .o_stall_if (o_stall_if),
    .o_stall_mem(o_stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit run      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic fail_now(input string name, input int got, input int want);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t dm_q[$];

  // Fetches use 0x000-0x0FC (never written); data accesses use 0x200-0x2FC.
  logic [31:0] phys_mem [256];
  logic [31:0] ref_mem  [256];
  int          line_cyc [16];
  logic [31:0] line_dat [16];

  // Memory: read data appears exactly MEM_LAT cycles after the read strobe, noise otherwise.
  always @(negedge clk) begin
    int s;
    s = (cyc + MEM_LAT) % 16;
    if (o_mem_re === 1'b1) begin
      line_cyc[s] = cyc + MEM_LAT;
      line_dat[s] = phys_mem[o_mem_addr[9:2]];
    end
    if (o_mem_we === 1'b1) phys_mem[o_mem_addr[9:2]] = o_mem_wdata;
  end

  always @(posedge clk) begin
    int s;
    #1;
    s = cyc % 16;
    i_mem_rdata = (line_cyc[s] == cyc) ? line_dat[s] : $urandom;
  end

  // Reference model state, in terms of cycles rather than FSM states.
  int          m_busy       = 0;
  bit          m_last_dm    = 1'b0;
  int          m_if_vld_cyc = -1;
  int          m_dm_vld_cyc = -1;
  int          m_if_new_cyc = -1;
  int          m_dm_new_cyc = -1;
  logic [31:0] m_if_new_dat;
  logic [31:0] m_dm_new_dat;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  always @(negedge clk) begin
    int          c;
    int          done;
    bit          m_if_vld;
    bit          m_dm_vld;
    bit          eff_if;
    bit          eff_dm;
    bit          g_dm;
    logic        e_re;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] d;
    c = cyc;
    if (c == m_if_new_cyc) exp_if_rdata = m_if_new_dat;
    if (c == m_dm_new_cyc) exp_dm_rdata = m_dm_new_dat;
    m_if_vld = (c == m_if_vld_cyc);
    m_dm_vld = (c == m_dm_vld_cyc);
    chk("if_rdata_hold", o_if_rdata, exp_if_rdata);
    chk("dm_rdata_hold", o_dm_rdata, exp_dm_rdata);
    chk("stall_if", o_stall_if, i_if_req & ~m_if_vld);
    chk("stall_mem", o_stall_mem, i_dm_req & ~m_dm_vld);
    eff_if = i_if_req & ~m_if_vld;
    eff_dm = i_dm_req & ~m_dm_vld;
    e_re = 1'b0;
    e_we = 1'b0;
    e_addr = '0;
    e_wd = '0;
    if (i_reset) begin
      m_busy       = c + 1;
      m_last_dm    = 1'b0;
      m_if_vld_cyc = -1;
      m_dm_vld_cyc = -1;
      m_if_new_cyc = -1;
      m_dm_new_cyc = -1;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
      while (if_q.size() > 0 && if_q[$].cyc > c) void'(if_q.pop_back());
      while (dm_q.size() > 0 && dm_q[$].cyc > c) void'(dm_q.pop_back());
    end else if (c >= m_busy && (eff_if || eff_dm)) begin
      g_dm = eff_dm && (!eff_if || !m_last_dm);
      m_last_dm = g_dm;
      if (!g_dm) begin
        e_re = 1'b1;
        e_addr = i_if_addr;
        d = ref_mem[i_if_addr[9:2]];
        done = c + MEM_LAT + 1;
        if_q.push_back('{cyc: done, data: d});
        m_if_vld_cyc = done;
        m_if_new_cyc = done;
        m_if_new_dat = d;
        m_busy = done;
      end else begin
        e_addr = i_dm_addr;
        e_wd = i_dm_wdata;
        if (i_dm_we) begin
          e_we = 1'b1;
          ref_mem[i_dm_addr[9:2]] = i_dm_wdata;
          done = c + 1;
          dm_q.push_back('{cyc: done, data: exp_dm_rdata});
        end else begin
          e_re = 1'b1;
          d = ref_mem[i_dm_addr[9:2]];
          done = c + MEM_LAT + 1;
          dm_q.push_back('{cyc: done, data: d});
          m_dm_new_cyc = done;
          m_dm_new_dat = d;
        end
        m_dm_vld_cyc = done;
        m_busy = done;
      end
    end
    chk("mem_re_we", {o_mem_re, o_mem_we}, {e_re, e_we});
    chk("mem_addr", o_mem_addr, e_addr);
    chk("mem_wdata", o_mem_wdata, e_wd);
  end

  // Monitor: pops an expected completion whenever a valid pulse is presented.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (if_q.size() > 0 && if_q[0].cyc < cyc) begin
      fail_now("if_valid_missing", cyc, if_q[0].cyc);
      void'(if_q.pop_front());
    end
    if (dm_q.size() > 0 && dm_q[0].cyc < cyc) begin
      fail_now("dm_valid_missing", cyc, dm_q[0].cyc);
      void'(dm_q.pop_front());
    end
    if (o_if_valid === 1'b1) begin
      if (if_q.size() == 0) begin
        fail_now("if_valid_spurious", 1, 0);
      end else begin
        e = if_q.pop_front();
        chk("if_valid_cycle", 64'(cyc), 64'(e.cyc));
        chk("if_valid_data", o_if_rdata, e.data);
      end
    end
    if (o_dm_valid === 1'b1) begin
      if (dm_q.size() == 0) begin
        fail_now("dm_valid_spurious", 1, 0);
      end else begin
        e = dm_q.pop_front();
        chk("dm_valid_cycle", 64'(cyc), 64'(e.cyc));
        chk("dm_valid_data", o_dm_rdata, e.data);
      end
    end
  end

  // Fetch requester: holds its request until valid, then moves on or goes quiet.
  initial begin
    logic [5:0] idx;
    i_if_req  = 1'b0;
    i_if_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (o_if_valid === 1'b1 || !i_if_req) begin
        if (run && $urandom_range(0, 3) != 0) begin
          idx = 6'($urandom_range(0, 63));
          i_if_req  = 1'b1;
          i_if_addr = {22'd0, idx, 2'b00};
        end else begin
          i_if_req = 1'b0;
        end
      end
    end
  end

  // Data requester: random mix of loads and stores within its own region.
  initial begin
    logic [5:0] idx;
    i_dm_req   = 1'b0;
    i_dm_we    = 1'b0;
    i_dm_addr  = '0;
    i_dm_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (o_dm_valid === 1'b1 || !i_dm_req) begin
        if (run && $urandom_range(0, 3) != 0) begin
          idx = 6'($urandom_range(0, 63));
          i_dm_req   = 1'b1;
          i_dm_we    = ($urandom_range(0, 2) == 0);
          i_dm_addr  = 32'h200 | {22'd0, idx, 2'b00};
          i_dm_wdata = $urandom;
        end else begin
          i_dm_req = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      phys_mem[i] = v;
      ref_mem[i]  = v;
    end
    for (int i = 0; i < 16; i++) line_cyc[i] = -1;
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      i_reset = ($urandom_range(0, 149) == 0);
    end
    i_reset = 1'b0;
    run = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2;
    chk("if_queue_drained", 64'(if_q.size()), 64'd0);
    chk("dm_queue_drained", 64'(dm_q.size()), 64'd0);
    chk("if_req_released", i_if_req, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
